// File: rtl/qpsk_demod.sv
// Coherent QPSK demodulator: integrate-and-dump correlation of a
// 16-sample symbol against cos/sin references, with sign decisions.
module qpsk_demod #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              sync_in,
  output logic              I_bit,
  output logic              Q_bit,
  output logic              bits_valid,
  output logic [ACC_W-1:0]  corr_i,
  output logic [ACC_W-1:0]  corr_q,
  output logic [15:0]       sym_count
);

  localparam int PW = DATA_W + COEF_W;

  function automatic logic signed [COEF_W-1:0] cos_lut(input logic [3:0] k);
    logic signed [COEF_W-1:0] c;
    case (k)
      4'd0:    c = COEF_W'(127);
      4'd1:    c = COEF_W'(117);
      4'd2:    c = COEF_W'(90);
      4'd3:    c = COEF_W'(49);
      4'd4:    c = COEF_W'(0);
      4'd5:    c = COEF_W'(-49);
      4'd6:    c = COEF_W'(-90);
      4'd7:    c = COEF_W'(-117);
      4'd8:    c = COEF_W'(-127);
      4'd9:    c = COEF_W'(-117);
      4'd10:   c = COEF_W'(-90);
      4'd11:   c = COEF_W'(-49);
      4'd12:   c = COEF_W'(0);
      4'd13:   c = COEF_W'(49);
      4'd14:   c = COEF_W'(90);
      default: c = COEF_W'(117);
    endcase
    return c;
  endfunction

  logic [3:0]        k_q, k_d, idx;
  logic              s1_v_q, s1_v_d;
  logic              s1_sync_q, s1_sync_d;
  logic [3:0]        s1_tag_q, s1_tag_d;
  logic [ACC_W-1:0]  p_i_q, p_i_d, p_q_q, p_q_d;
  logic signed [PW-1:0] prod_i, prod_q;

  logic [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [ACC_W-1:0]  sum_i, sum_q;
  logic [ACC_W-1:0]  corr_i_q, corr_i_d, corr_q_q, corr_q_d;
  logic              i_bit_q, i_bit_d, q_bit_q, q_bit_d;
  logic              bv_q, bv_d;
  logic [15:0]       cnt_q, cnt_d;

  // Stage 1: index tracking and reference multiply
  always_comb begin
    idx    = sync_in ? 4'd0 : k_q;
    prod_i = $signed(sample_in) * cos_lut(idx);
    prod_q = $signed(sample_in) * cos_lut(idx + 4'd12);
    k_d       = k_q;
    s1_v_d    = sample_valid;
    s1_sync_d = s1_sync_q;
    s1_tag_d  = s1_tag_q;
    p_i_d     = p_i_q;
    p_q_d     = p_q_q;
    if (sample_valid) begin
      k_d       = idx + 4'd1;
      s1_sync_d = sync_in;
      s1_tag_d  = idx;
      p_i_d     = {{(ACC_W-PW){prod_i[PW-1]}}, prod_i};
      p_q_d     = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
    end
  end

  // Stage 2: accumulate; a sync-tagged product restarts the sum
  always_comb begin
    sum_i    = (s1_sync_q ? '0 : acc_i_q) + p_i_q;
    sum_q    = (s1_sync_q ? '0 : acc_q_q) + p_q_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    corr_i_d = corr_i_q;
    corr_q_d = corr_q_q;
    i_bit_d  = i_bit_q;
    q_bit_d  = q_bit_q;
    bv_d     = 1'b0;
    cnt_d    = cnt_q;
    if (s1_v_q) begin
      if (s1_tag_q == 4'd15) begin
        corr_i_d = sum_i;
        corr_q_d = sum_q;
        i_bit_d  = sum_i[ACC_W-1];
        q_bit_d  = sum_q[ACC_W-1];
        bv_d     = 1'b1;
        acc_i_d  = '0;
        acc_q_d  = '0;
        cnt_d    = cnt_q + 16'd1;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      s1_v_q    <= 1'b0;
      s1_sync_q <= 1'b0;
      s1_tag_q  <= '0;
      p_i_q     <= '0;
      p_q_q     <= '0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      corr_i_q  <= '0;
      corr_q_q  <= '0;
      i_bit_q   <= 1'b0;
      q_bit_q   <= 1'b0;
      bv_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      k_q       <= k_d;
      s1_v_q    <= s1_v_d;
      s1_sync_q <= s1_sync_d;
      s1_tag_q  <= s1_tag_d;
      p_i_q     <= p_i_d;
      p_q_q     <= p_q_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      corr_i_q  <= corr_i_d;
      corr_q_q  <= corr_q_d;
      i_bit_q   <= i_bit_d;
      q_bit_q   <= q_bit_d;
      bv_q      <= bv_d;
      cnt_q     <= cnt_d;
    end
  end

  assign I_bit      = i_bit_q;
  assign Q_bit      = q_bit_q;
  assign bits_valid = bv_q;
  assign corr_i     = corr_i_q;
  assign corr_q     = corr_q_q;
  assign sym_count  = cnt_q;

endmodule

// File: doc/qpsk_demod.md
# qpsk_demod

Coherent QPSK demodulator that sits directly downstream of the QPSK modulator output. It consumes the 10-bit signed sample stream and correlates each symbol period against internal cosine and sine references using integrate-and-dump. It then recovers the I/Q bit pair and reports the raw correlations for observation. Symbol alignment comes from an explicit sync strobe; carrier phase is assumed coherent with the modulator's tables.

## Interface
- DATA_W, 10, sample width (signed two's complement)
- COEF_W, 8, reference coefficient width (signed)
- ACC_W, 22, accumulator/correlation width; must be ≥ DATA_W+COEF_W+4
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- sample_in  input  DATA_W  signed modulated sample
- sample_valid  input  1  sample_in is valid this cycle
- sync_in  input  1  qualified by sample_valid; marks sample index 0 of a symbol
- I_bit  output  1  recovered I decision
- Q_bit  output  1  recovered Q decision
- bits_valid  output  1  one-cycle pulse, new I_bit/Q_bit/corr values
- corr_i  output  ACC_W  signed Σ sample·cos over last symbol
- corr_q  output  ACC_W  signed Σ sample·sin over last symbol
- sym_count  output  16  symbols decided since reset, wraps 0xFFFF→0

## Operation
- 16 samples per symbol, one carrier cycle per symbol.
- Index counter k (4 bits):
  - advances by 1 (mod 16) on each sample_valid;
  - sample_valid with sync_in forces that sample's index to 0.
- cos LUT, k=0..15: 127,117,90,49,0,-49,-90,-117,-127,-117,-90,-49,0,49,90,117. sin[k]=cos[(k+12) mod 16].
- Stage 1 (edge after accepted sample): register p_i=sample·cos[k], p_q=sample·sin[k], full signed product sign-extended to ACC_W. Also register valid, tag k and the sync flag.
- Stage 2 (next edge, when stage-1 valid):
  - sync flag set → acc ← p (restart); any partial symbol is discarded with no output.
  - otherwise acc ← acc + p.
  - tag==15 → corr_i/corr_q ← final sum, I_bit ← sign(corr_i), Q_bit ← sign(corr_q), bits_valid ← 1, acc ← 0, sym_count += 1.
- Decision: negative correlation → bit 1; zero or positive → bit 0.
- Bubbles (sample_valid=0) add nothing and do not advance k; they may occur anywhere, including mid-symbol.
- sync_in without sample_valid is ignored.
- Arithmetic is wrapping two's complement. Overflow cannot occur at ACC_W=22: worst case 512·1278=654336.

## Timing
- Reset (async, rst_n low): k=0, acc=0, pipeline valids=0, I_bit=0, Q_bit=0, bits_valid=0, corr_i=0, corr_q=0, sym_count=0.
- Latency: 16th sample (tag 15) presented in cycle n → bits_valid high in cycle n+2 for exactly one cycle. Outputs hold until the next bits_valid.
- Throughput: one sample per clk; back-to-back symbols give bits_valid every 16 cycles with no dead cycle.
- Sync on the same sample as a tag-15 completion is impossible; sync forces tag 0.
- Sync arriving at k=15 aborts that symbol: no bits_valid, and sym_count is unchanged.
- Reset mid-symbol discards in-flight products; the first symbol after reset starts at k=0.

## Test plan
- Reset, then sync + 16 consecutive samples x[k]=cos[k] → cycle n+2: bits_valid=1, corr_i=129018, corr_q=0, I_bit=0, Q_bit=0, sym_count=1.
- Same with x[k]=-cos[k], then next symbol x[k]=sin[k] back-to-back → corr_i=-129018/I_bit=1. Then 16 cycles later: corr_q=129018, corr_i=0, Q_bit=0; sym_count=2.
- Constant x=511 for 16 samples → corr_i=0, corr_q=0, bits 0/0. Then x=-512·sign(cos[k]+sin[k]) full-scale → no wrap; values match a reference model.
- Random bubbles (sample_valid ~50%) through a -sin symbol → identical corr/bits to the gap-free run; bits_valid 2 cycles after the 16th valid sample.
- sync_in reasserted at k=9, then 16 samples of cos → no output for the aborted symbol; one bits_valid with corr_i=129018.
- rst_n pulsed low asynchronously mid-symbol → all outputs 0 immediately. A following synced cos symbol yields sym_count=1.
